pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL take parameter NUM_REGS, default 32: architectural register count; register index width is RW = clog2(NUM_REGS).
REQ-002 SHALL take parameter LOAD_LATENCY, default 1: cycles after EX before load data can be forwarded; legal range 1..7.
REQ-003 SHALL take parameter FLUSH_CYCLES, default 1: cycles flush stays asserted per redirect; legal range 1..4.
REQ-004 SHALL take parameter MAX_STALL, default 15: consecutive stall cycles allowed before timeout.
REQ-005 SHALL take parameter CNT_W, default 32: width of the performance counters.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  system clock; all state updates on its rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 id_valid  in  1  ID stage holds a real instruction.
REQ-010 id_rs1, id_rs2  in  RW  ID source register indices.
REQ-011 id_uses_rs1, id_uses_rs2  in  1  ID instruction reads that source.
REQ-012 ex_valid, ex_reg_write, ex_is_load  in  1  EX stage valid, writes rd, is a load.
REQ-013 ex_rd  in  RW  EX destination register.
REQ-014 redirect  in  1  EX resolved a taken branch or a jump (jal/jalr).
REQ-015 stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-016 flush  out  1  invalidate IF/ID and ID/EX.
REQ-017 stall_timeout  out  1  sticky error flag.
REQ-018 stall_count, flush_count  out  CNT_W  saturating event counters.

Function
REQ-019 SHALL keep a per-register scoreboard counter of width 3; x0 never pending.
REQ-020 A load in EX (ex_valid & ex_is_load & ex_reg_write & ex_rd!=0 & !redirect) SHALL load cnt[ex_rd] with LOAD_LATENCY-1 at the next edge; every other nonzero cnt SHALL decrement by 1 each cycle.
REQ-021 A source is hazardous when it is used, nonzero, and either matches the qualifying EX load of REQ-020 in the same cycle or has cnt != 0.
REQ-022 stall SHALL be combinational: id_valid & (hazard on rs1 | hazard on rs2) & !flush.
REQ-023 With LOAD_LATENCY=L, a dependent instruction directly behind a load SHALL stall exactly L cycles.
REQ-024 The flush FSM SHALL have states IDLE and FLUSH plus a down-counter; flush = redirect | (state==FLUSH).
REQ-025 On redirect: if FLUSH_CYCLES>1, go to FLUSH with counter FLUSH_CYCLES-1; otherwise stay in IDLE. In FLUSH, decrement; return to IDLE when the counter reaches 1; a redirect inside FLUSH SHALL restart the count.
REQ-026 flush SHALL take priority over stall; the scoreboard is not cleared by flush.
REQ-027 A consecutive-stall counter SHALL clear on any non-stall cycle; stall_timeout SHALL set when it exceeds MAX_STALL and hold until rst.
REQ-028 stall_count SHALL increment per stall cycle and flush_count per flush cycle; both saturate at all-ones.

Reset
REQ-029 On rst, scoreboard, FSM (IDLE), all counters and stall_timeout SHALL clear; stall=0 and flush=0 in the cycle after rst is sampled.
REQ-030 rst asserted mid-stall or mid-flush SHALL abort it; no residual stall or flush after release.

Structure
REQ-031 Parameter defaults and the flush-state enum SHALL live in the shared package hazard_pkg.
REQ-032 Scoreboard storage and the countdown logic SHALL be the sub-module hazard_scoreboard; the FSM, watchdog and counters stay in pipeline_hazard_ctrl.

Verification
REQ-033 L=1: lw x3,0(x1) in EX, then add x4,x1,x3 in ID -> stall for 1 cycle, stall_count=1.
REQ-034 L=3: same pair -> stall for 3 consecutive cycles, then released; rd=x0 load -> no stall.
REQ-035 FLUSH_CYCLES=2: redirect pulse while ID has a hazard -> flush for 2 cycles, stall=0 both cycles, flush_count=2.
REQ-036 MAX_STALL=2, L=5: dependent pair -> stall_timeout sets on the 3rd stall cycle and holds after the stall ends.
REQ-037 CNT_W=4: 20 stall cycles -> stall_count=4'hF. rst during a 3-cycle stall -> next cycle stall=0, counters=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared defaults and flush FSM state type for the hazard controller
package hazard_pkg;
    localparam int DEF_NUM_REGS     = 32;
    localparam int DEF_LOAD_LATENCY = 1;
    localparam int DEF_FLUSH_CYCLES = 1;
    localparam int DEF_MAX_STALL    = 15;
    localparam int DEF_CNT_W        = 32;
    localparam int SB_W             = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;
endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register load countdown and source hazard detection
import hazard_pkg::*;

module hazard_scoreboard #(
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int LOAD_LATENCY = DEF_LOAD_LATENCY,
    localparam int RW          = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [RW-1:0] load_rd,
    input  logic [RW-1:0] rs1,
    input  logic          use_rs1,
    input  logic [RW-1:0] rs2,
    input  logic          use_rs2,
    output logic          hazard_rs1,
    output logic          hazard_rs2
);
    localparam logic [SB_W-1:0] LD_INIT = SB_W'(LOAD_LATENCY - 1);

    logic [SB_W-1:0] cnt [NUM_REGS];

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst || r == 0) begin
                cnt[r] <= '0;
            end else if (load_valid && load_rd == RW'(r)) begin
                cnt[r] <= LD_INIT;
            end else if (cnt[r] != '0) begin
                cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    // The load sitting in EX right now is not in cnt yet, so it is matched directly.
    function automatic logic src_hazard(input logic used, input logic [RW-1:0] idx);
        return used && (idx != '0) &&
               ((load_valid && load_rd == idx) || (cnt[idx] != '0));
    endfunction

    assign hazard_rs1 = src_hazard(use_rs1, rs1);
    assign hazard_rs2 = src_hazard(use_rs2, rs2);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, redirect flush, stall watchdog and event counters
import hazard_pkg::*;

module pipeline_hazard_ctrl #(
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int LOAD_LATENCY = DEF_LOAD_LATENCY,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int MAX_STALL    = DEF_MAX_STALL,
    parameter int CNT_W        = DEF_CNT_W,
    localparam int RW          = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_rs1,
    input  logic [RW-1:0]    id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_reg_write,
    input  logic             ex_is_load,
    input  logic [RW-1:0]    ex_rd,
    input  logic             redirect,
    output logic             stall,
    output logic             flush,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    localparam int CW = $clog2(MAX_STALL + 2);

    flush_state_e  state;
    logic [2:0]    fcnt;
    logic [CW-1:0] consec;
    logic          load_valid;
    logic          hazard_rs1;
    logic          hazard_rs2;

    assign load_valid = ex_valid && ex_is_load && ex_reg_write && (ex_rd != '0) && !redirect;

    hazard_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .LOAD_LATENCY (LOAD_LATENCY)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_rd    (ex_rd),
        .rs1        (id_rs1),
        .use_rs1    (id_uses_rs1),
        .rs2        (id_rs2),
        .use_rs2    (id_uses_rs2),
        .hazard_rs1 (hazard_rs1),
        .hazard_rs2 (hazard_rs2)
    );

    assign flush = redirect || (state == ST_FLUSH);
    assign stall = id_valid && (hazard_rs1 || hazard_rs2) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            fcnt  <= '0;
        end else if (redirect) begin
            if (FLUSH_CYCLES > 1) begin
                state <= ST_FLUSH;
                fcnt  <= 3'(FLUSH_CYCLES - 1);
            end
        end else if (state == ST_FLUSH) begin
            if (fcnt == 3'd1) begin
                state <= ST_IDLE;
            end else begin
                fcnt <= fcnt - 1'b1;
            end
        end
    end

    // consec saturates one past MAX_STALL so it never wraps during a long stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            consec        <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (!stall) begin
                consec <= '0;
            end else if (consec != CW'(MAX_STALL + 1)) begin
                consec <= consec + 1'b1;
            end
            if (stall && consec >= CW'(MAX_STALL)) begin
                stall_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
            if (flush && flush_count != '1) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed tests for pipeline_hazard_ctrl across several parameter sets
module tb_pipeline_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_valid;
    logic       ex_reg_write;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic       redirect;

    logic        a_stall, a_flush, a_timeout;
    logic [31:0] a_stall_count, a_flush_count;
    logic        b_stall, b_flush, b_timeout;
    logic [3:0]  b_stall_count, b_flush_count;
    logic        c_stall, c_flush, c_timeout;
    logic [31:0] c_stall_count, c_flush_count;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_LATENCY(1), .FLUSH_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .redirect(redirect),
        .stall(a_stall), .flush(a_flush), .stall_timeout(a_timeout),
        .stall_count(a_stall_count), .flush_count(a_flush_count)
    );

    pipeline_hazard_ctrl #(.LOAD_LATENCY(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .redirect(redirect),
        .stall(b_stall), .flush(b_flush), .stall_timeout(b_timeout),
        .stall_count(b_stall_count), .flush_count(b_flush_count)
    );

    pipeline_hazard_ctrl #(.LOAD_LATENCY(5), .MAX_STALL(2)) dut_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .redirect(redirect),
        .stall(c_stall), .flush(c_flush), .stall_timeout(c_timeout),
        .stall_count(c_stall_count), .flush_count(c_flush_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_valid = 0; ex_reg_write = 0; ex_is_load = 0; ex_rd = 0; redirect = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
    endtask

    // lw x3 in EX, add x4,x1,x3 in ID
    task automatic load_and_dep(input logic [4:0] rd);
        ex_valid = 1; ex_reg_write = 1; ex_is_load = 1; ex_rd = rd;
        id_valid = 1; id_rs1 = 5'd1; id_rs2 = rd; id_uses_rs1 = 1; id_uses_rs2 = 1;
    endtask

    task automatic ex_bubble();
        ex_valid = 0; ex_reg_write = 0; ex_is_load = 0; ex_rd = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        compared++;
        if ({a_stall, a_flush, a_timeout} !== 3'b000 || a_stall_count !== 32'd0 || a_flush_count !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_a: got stall=%b flush=%b to=%b sc=%0d fc=%0d want all 0",
                     a_stall, a_flush, a_timeout, a_stall_count, a_flush_count);
        end
        compared++;
        if ({b_stall, b_flush, b_timeout} !== 3'b000 || b_stall_count !== 4'd0 || b_flush_count !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_b: got stall=%b flush=%b to=%b sc=%0d fc=%0d want all 0",
                     b_stall, b_flush, b_timeout, b_stall_count, b_flush_count);
        end
        compared++;
        if ({c_stall, c_flush, c_timeout} !== 3'b000 || c_stall_count !== 32'd0 || c_flush_count !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_c: got stall=%b flush=%b to=%b sc=%0d fc=%0d want all 0",
                     c_stall, c_flush, c_timeout, c_stall_count, c_flush_count);
        end
    endtask

    task automatic test_load_l1();
        do_reset();
        load_and_dep(5'd3);
        #1;
        compared++;
        if (a_stall !== 1'b1) begin mismatched++; $display("FAIL l1_stall_c0: got %b want 1", a_stall); end
        tick();
        ex_bubble();
        #1;
        compared++;
        if (a_stall !== 1'b0) begin mismatched++; $display("FAIL l1_stall_c1: got %b want 0", a_stall); end
        compared++;
        if (a_stall_count !== 32'd1) begin mismatched++; $display("FAIL l1_stall_count: got %0d want 1", a_stall_count); end
    endtask

    task automatic test_load_l3();
        do_reset();
        load_and_dep(5'd3);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                tick();
                ex_bubble();
            end
            #1;
            compared++;
            if (b_stall !== (c < 3)) begin
                mismatched++;
                $display("FAIL l3_stall_c%0d: got %b want %b", c, b_stall, (c < 3));
            end
        end
        compared++;
        if (b_stall_count !== 4'd3) begin mismatched++; $display("FAIL l3_stall_count: got %0d want 3", b_stall_count); end
        do_reset();
        load_and_dep(5'd0);
        #1;
        compared++;
        if (b_stall !== 1'b0) begin mismatched++; $display("FAIL l3_x0_load_c0: got %b want 0", b_stall); end
        tick();
        ex_bubble();
        #1;
        compared++;
        if (b_stall !== 1'b0) begin mismatched++; $display("FAIL l3_x0_load_c1: got %b want 0", b_stall); end
    endtask

    task automatic test_flush();
        do_reset();
        load_and_dep(5'd3);
        tick();
        ex_bubble();
        redirect = 1;
        #1;
        compared++;
        if ({b_flush, b_stall} !== 2'b10) begin mismatched++; $display("FAIL flush_b_c1: got flush,stall=%b%b want 10", b_flush, b_stall); end
        compared++;
        if (a_flush !== 1'b1) begin mismatched++; $display("FAIL flush_a_c1: got %b want 1", a_flush); end
        tick();
        redirect = 0;
        #1;
        compared++;
        if ({b_flush, b_stall} !== 2'b10) begin mismatched++; $display("FAIL flush_b_c2: got flush,stall=%b%b want 10", b_flush, b_stall); end
        compared++;
        if (a_flush !== 1'b0) begin mismatched++; $display("FAIL flush_a_c2: got %b want 0", a_flush); end
        tick();
        #1;
        compared++;
        if ({b_flush, b_stall} !== 2'b00) begin mismatched++; $display("FAIL flush_b_c3: got flush,stall=%b%b want 00", b_flush, b_stall); end
        compared++;
        if (b_flush_count !== 4'd2 || b_stall_count !== 4'd1) begin
            mismatched++;
            $display("FAIL flush_b_counts: got fc=%0d sc=%0d want fc=2 sc=1", b_flush_count, b_stall_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        redirect = 1;
        tick();
        #1;
        tick();
        redirect = 0;
        #1;
        compared++;
        if (b_flush !== 1'b1) begin mismatched++; $display("FAIL b2b_restart: got %b want 1", b_flush); end
        tick();
        #1;
        compared++;
        if (b_flush !== 1'b0 || b_flush_count !== 4'd3) begin
            mismatched++;
            $display("FAIL b2b_end: got flush=%b fc=%0d want flush=0 fc=3", b_flush, b_flush_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        load_and_dep(5'd3);
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin
                tick();
                ex_bubble();
            end
            #1;
            if (c < 6) begin
                compared++;
                if (c_stall !== (c < 5)) begin
                    mismatched++;
                    $display("FAIL to_stall_c%0d: got %b want %b", c, c_stall, (c < 5));
                end
            end
            compared++;
            if (c_timeout !== (c >= 3)) begin
                mismatched++;
                $display("FAIL to_flag_c%0d: got %b want %b", c, c_timeout, (c >= 3));
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        load_and_dep(5'd3);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) begin
                compared++;
                if (b_stall_count !== 4'hE) begin mismatched++; $display("FAIL sat_14: got %h want e", b_stall_count); end
            end
        end
        compared++;
        if (b_stall_count !== 4'hF) begin mismatched++; $display("FAIL sat_20: got %h want f", b_stall_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_and_dep(5'd3);
        tick();
        ex_bubble();
        rst = 1;
        tick();
        rst = 0;
        #1;
        compared++;
        if (b_stall !== 1'b0 || b_stall_count !== 4'd0 || b_flush_count !== 4'd0) begin
            mismatched++;
            $display("FAIL rst_mid_stall: got stall=%b sc=%0d fc=%0d want 0 0 0", b_stall, b_stall_count, b_flush_count);
        end
        do_reset();
        redirect = 1;
        tick();
        redirect = 0;
        rst = 1;
        tick();
        rst = 0;
        #1;
        compared++;
        if (b_flush !== 1'b0 || b_flush_count !== 4'd0) begin
            mismatched++;
            $display("FAIL rst_mid_flush: got flush=%b fc=%0d want 0 0", b_flush, b_flush_count);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_load_l1();
        test_load_l3();
        test_flush();
        test_back_to_back();
        test_timeout();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
